// File: rtl/obuf_arb_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// obuf_arb_ctrl_pkg
// Constants shared by the router's input-buffer controllers, route
// computation and the per-direction output arbiter/buffer.
//   dir_e      : port/direction indices (N=0, W=1, S=2, E=3, B=4)
//   NUM_PORTS  : number of router ports
//   PYLD_W_DEF : default flit payload width
//   next_ptr() : rotating-priority pointer that follows a given winner
// ---------------------------------------------------------------------------
package obuf_arb_ctrl_pkg;

  localparam int NUM_PORTS  = 5;
  localparam int PYLD_W_DEF = 23;

  typedef enum logic [2:0] {
    DIR_N = 3'd0,
    DIR_W = 3'd1,
    DIR_S = 3'd2,
    DIR_E = 3'd3,
    DIR_B = 3'd4
  } dir_e;

  // The priority pointer moves to the port just after the winner, wrapping B->N.
  function automatic logic [2:0] next_ptr(input logic [2:0] win);
    logic [2:0] nxt;
    if (win >= 3'(DIR_B)) begin
      nxt = 3'(DIR_N);
    end else begin
      nxt = win + 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/obuf_arb_ctrl_rr_arb5.sv
// ---------------------------------------------------------------------------
// rr_arb5
// Purely combinational five-way rotating-priority arbiter. The first set
// request bit at or after ptr (wrapping 4->0) wins.
//   req[4:0] : request vector, index = direction
//   ptr[2:0] : highest-priority index (0..4)
//   gnt[4:0] : one-hot grant, all-zero when req is zero
//   win[2:0] : index of the winner (0 when nothing is granted)
// ---------------------------------------------------------------------------
module rr_arb5
  import obuf_arb_ctrl_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [4:0] gnt,
  output logic [2:0] win
);

  logic [2:0] start_s;
  logic [3:0] idx_s;
  logic       found_s;
  logic [4:0] gnt_s;
  logic [2:0] win_s;

  // Scan the five positions starting at ptr and keep the first requester.
  always_comb begin
    gnt_s   = 5'b00000;
    win_s   = 3'd0;
    found_s = 1'b0;
    idx_s   = 4'd0;
    // An out-of-range pointer is treated as N so the arbiter never stalls.
    if (ptr > 3'(DIR_B)) begin
      start_s = 3'(DIR_N);
    end else begin
      start_s = ptr;
    end
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx_s = {1'b0, start_s} + k[3:0];
      if (idx_s >= 4'd5) begin
        idx_s = idx_s - 4'd5;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req[idx_s[2:0]]) begin
        found_s             = 1'b1;
        gnt_s[idx_s[2:0]]   = 1'b1;
        win_s               = idx_s[2:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  assign gnt = gnt_s;
  assign win = win_s;

endmodule

// File: rtl/obuf_arb_ctrl.sv
// ---------------------------------------------------------------------------
// obuf_arb_ctrl
// Per-output-direction arbiter and output FIFO. Picks one of the five input
// controllers by rotating priority, stores the winning flit and presents the
// FIFO head to the link / local sink.
//   clk, rst   : clock, synchronous active-high reset
//   port_en    : output port enabled (0 = link down / power-gated)
//   arb_req    : per-input request bits (N,W,S,E,B = 0..4)
//   payload_i  : flattened payloads, port i at [i*PYLD_W +: PYLD_W]
//   arb_gnt    : one-hot grant (combinational), zero when disabled or idle
//   obuf_rdy   : FIFO can accept this cycle (registered state only)
//   out_vld    : head flit valid
//   out_rdy    : downstream accepts the head flit
//   out_data   : head flit
// ---------------------------------------------------------------------------
module obuf_arb_ctrl
  import obuf_arb_ctrl_pkg::*;
#(
  parameter int PYLD_W = PYLD_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  port_en,
  input  logic [4:0]            arb_req,
  input  logic [5*PYLD_W-1:0]   payload_i,
  output logic [4:0]            arb_gnt,
  output logic                  obuf_rdy,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [PYLD_W-1:0]     out_data
);

  // Only 2 or 4 entries are supported; pointers are 1 or 2 bits wide.
  localparam int AW    = (DEPTH == 4) ? 2 : 1;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [AW-1:0]    LAST_C  = AW'(DEPTH - 1);

  logic [2:0]        ptr_r;
  logic [AW-1:0]     wptr_r;
  logic [AW-1:0]     rptr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              out_vld_r;
  logic [PYLD_W-1:0] mem_r [DEPTH];

  logic [4:0]        gnt_s;
  logic [2:0]        win_s;
  logic              acc_s;
  logic              pop_s;
  logic              rdy_s;
  logic [PYLD_W-1:0] pyld_sel_s;

  rr_arb5 u_rr_arb5 (
    .req (arb_req),
    .ptr (ptr_r),
    .gnt (gnt_s),
    .win (win_s)
  );

  // Ready comes from the registered count only, never from out_rdy.
  assign rdy_s    = port_en & (cnt_r != DEPTH_C);
  assign arb_gnt  = port_en ? gnt_s : 5'b00000;
  assign obuf_rdy = rdy_s;
  assign acc_s    = (|(arb_req & arb_gnt)) & rdy_s;
  assign pop_s    = out_vld_r & out_rdy;
  assign out_vld  = out_vld_r;
  assign out_data = mem_r[rptr_r];

  // Select the winning input's payload for the FIFO write.
  always_comb begin
    pyld_sel_s = {PYLD_W{1'b0}};
    case (win_s)
      3'(DIR_N): pyld_sel_s = payload_i[0*PYLD_W +: PYLD_W];
      3'(DIR_W): pyld_sel_s = payload_i[1*PYLD_W +: PYLD_W];
      3'(DIR_S): pyld_sel_s = payload_i[2*PYLD_W +: PYLD_W];
      3'(DIR_E): pyld_sel_s = payload_i[3*PYLD_W +: PYLD_W];
      3'(DIR_B): pyld_sel_s = payload_i[4*PYLD_W +: PYLD_W];
      default:   pyld_sel_s = {PYLD_W{1'b0}};
    endcase
  end

  // Occupancy update: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (acc_s && !pop_s) begin
      cnt_nxt_s = cnt_r + 3'd1;
    end else if (pop_s && !acc_s) begin
      cnt_nxt_s = cnt_r - 3'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Control state: priority pointer, FIFO pointers, count and head-valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r     <= 3'(DIR_N);
      wptr_r    <= {AW{1'b0}};
      rptr_r    <= {AW{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      out_vld_r <= 1'b0;
    end else begin
      if (acc_s) begin
        ptr_r  <= next_ptr(win_s);
        wptr_r <= (wptr_r == LAST_C) ? {AW{1'b0}} : wptr_r + AW'(1);
      end
      if (pop_s) begin
        rptr_r <= (rptr_r == LAST_C) ? {AW{1'b0}} : rptr_r + AW'(1);
      end
      cnt_r     <= cnt_nxt_s;
      out_vld_r <= (cnt_nxt_s != {CNT_W{1'b0}});
    end
  end

  // FIFO storage; reset clears every entry so out_data reads zero when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {PYLD_W{1'b0}};
      end
    end else if (acc_s) begin
      mem_r[wptr_r] <= pyld_sel_s;
    end
  end

endmodule

// File: tb/tb_obuf_arb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_obuf_arb_ctrl
// Directed bench for obuf_arb_ctrl (DEPTH=2, PYLD_W=23). Inputs change just
// after the rising edge; outputs are checked a moment later, mid-cycle.
// ---------------------------------------------------------------------------
module tb_obuf_arb_ctrl;

  localparam int PW = 23;

  logic            clk = 1'b0;
  logic            rst;
  logic            port_en;
  logic [4:0]      arb_req;
  logic [5*PW-1:0] payload;
  logic [4:0]      arb_gnt;
  logic            obuf_rdy;
  logic            out_vld;
  logic            out_rdy;
  logic [PW-1:0]   out_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  obuf_arb_ctrl #(.PYLD_W(PW), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .port_en   (port_en),
    .arb_req   (arb_req),
    .payload_i (payload),
    .arb_gnt   (arb_gnt),
    .obuf_rdy  (obuf_rdy),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_data  (out_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_pl(input int i, input logic [PW-1:0] v);
    payload[i*PW +: PW] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [4:0]    exp_gnt;
    logic [PW-1:0] v;
    int            e;

    rst = 1'b1; port_en = 1'b1; arb_req = 5'b00000; out_rdy = 1'b0; payload = '0;
    step(); step();
    rst = 1'b0;
    settle();
    chk("rst_out_vld",  32'(out_vld),  32'd0);
    chk("rst_arb_gnt",  32'(arb_gnt),  32'd0);
    chk("rst_obuf_rdy", 32'(obuf_rdy), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);

    // Single flit from S.
    arb_req = 5'b00100; set_pl(2, 23'h1ABCD);
    settle();
    chk("single_gnt", 32'(arb_gnt), 32'b00100);
    step();
    arb_req = 5'b00000;
    settle();
    chk("single_vld",  32'(out_vld),  32'd1);
    chk("single_data", 32'(out_data), 32'h1ABCD);
    arb_req = 5'b11111;
    settle();
    chk("single_ptr3", 32'(arb_gnt), 32'b01000);
    arb_req = 5'b00000; out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    settle();
    chk("single_drained", 32'(out_vld), 32'd0);

    // Accept from B to bring the pointer back to N, then round-robin.
    arb_req = 5'b10000; set_pl(4, 23'h00444); out_rdy = 1'b1;
    settle();
    chk("rr_pre_gnt", 32'(arb_gnt), 32'b10000);
    step();
    arb_req = 5'b11111;
    settle();
    chk("rr_pre_data", 32'(out_data), 32'h00444);
    for (int s = 0; s < 6; s++) begin
      e = s % 5;
      for (int i = 0; i < 5; i++) begin
        v = 23'(32'h10000 + s * 16 + i);
        set_pl(i, v);
      end
      exp_gnt = 5'b00001 << e;
      settle();
      chk("rr_gnt", 32'(arb_gnt), 32'(exp_gnt));
      step();
      chk("rr_data", 32'(out_data), 32'h10000 + 32'(s * 16 + e));
      chk("rr_vld",  32'(out_vld),  32'd1);
    end
    arb_req = 5'b00000;
    step();
    out_rdy = 1'b0;
    settle();
    chk("rr_drained", 32'(out_vld), 32'd0);

    // Full / backpressure, pointer now at W.
    arb_req = 5'b00010; set_pl(1, 23'h0AAA1);
    settle();
    chk("full_gnt1", 32'(arb_gnt), 32'b00010);
    step();
    arb_req = 5'b00100; set_pl(2, 23'h0BBB2);
    step();
    arb_req = 5'b01000; set_pl(3, 23'h0CCC3);
    settle();
    chk("full_rdy0",    32'(obuf_rdy), 32'd0);
    chk("full_gnt3",    32'(arb_gnt),  32'b01000);
    chk("full_head",    32'(out_data), 32'h0AAA1);
    step();
    chk("full_hold",    32'(out_data), 32'h0AAA1);
    chk("full_rdy_hold", 32'(obuf_rdy), 32'd0);
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    settle();
    chk("full_pop_data", 32'(out_data), 32'h0BBB2);
    chk("full_pop_rdy",  32'(obuf_rdy), 32'd1);
    step();
    arb_req = 5'b00000;
    settle();
    chk("full_again_rdy", 32'(obuf_rdy), 32'd0);
    out_rdy = 1'b1;
    step();
    chk("full_drain_data", 32'(out_data), 32'h0CCC3);
    step();
    out_rdy = 1'b0;
    settle();
    chk("full_drained", 32'(out_vld), 32'd0);

    // Simultaneous push and pop at count 1, pointer at B.
    arb_req = 5'b10000; set_pl(4, 23'h0D004);
    step();
    arb_req = 5'b00001; set_pl(0, 23'h0E000); out_rdy = 1'b1;
    settle();
    chk("pp_gnt", 32'(arb_gnt), 32'b00001);
    step();
    arb_req = 5'b00000; out_rdy = 1'b0;
    settle();
    chk("pp_data", 32'(out_data), 32'h0E000);
    chk("pp_vld",  32'(out_vld),  32'd1);
    chk("pp_rdy",  32'(obuf_rdy), 32'd1);
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    settle();
    chk("pp_count1", 32'(out_vld), 32'd0);

    // Port disable with one flit stored, pointer brought to N via B.
    arb_req = 5'b10000; set_pl(4, 23'h0F004);
    step();
    port_en = 1'b0; arb_req = 5'b10001; set_pl(0, 23'h07770);
    settle();
    chk("dis_gnt",  32'(arb_gnt),  32'd0);
    chk("dis_rdy",  32'(obuf_rdy), 32'd0);
    chk("dis_vld",  32'(out_vld),  32'd1);
    chk("dis_data", 32'(out_data), 32'h0F004);
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    settle();
    chk("dis_popped", 32'(out_vld), 32'd0);
    chk("dis_gnt2",   32'(arb_gnt), 32'd0);
    port_en = 1'b1;
    settle();
    chk("en_gnt", 32'(arb_gnt),  32'b00001);
    chk("en_rdy", 32'(obuf_rdy), 32'd1);
    step();
    arb_req = 5'b00000;
    settle();
    chk("en_data", 32'(out_data), 32'h07770);
    chk("en_vld",  32'(out_vld),  32'd1);

    // Reset mid-operation with two flits stored.
    arb_req = 5'b00010; set_pl(1, 23'h01111);
    step();
    arb_req = 5'b00000;
    settle();
    chk("mid_full", 32'(obuf_rdy), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    chk("mid_vld",  32'(out_vld),  32'd0);
    chk("mid_rdy",  32'(obuf_rdy), 32'd1);
    chk("mid_data", 32'(out_data), 32'd0);
    arb_req = 5'b11111;
    settle();
    chk("mid_ptr0", 32'(arb_gnt), 32'b00001);
    arb_req = 5'b00000;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
